shift_sched: RTL

- Scheduler that shares one serial shift register (depth LEN) between NREQ requesters.
- Sequences the register's clock-enable and serial data input: flushes it to zero after reset, then grants fixed-length bursts round-robin.
- Sits between requesters and a shift_reg instance: o_ce drives the register's enable, o_sr_data drives its data input.

---
 rtl/shift_sched_pkg.sv | 29 ++
 rtl/shift_sched_rr_arbiter.sv | 35 +++
 rtl/shift_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// Shared state encoding and width helper for shift_sched.
// The FLUSH encoding exists only when SHIFT_SCHED_FLUSH_EN is defined.
package shift_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1
`ifdef SHIFT_SCHED_FLUSH_EN
      , ST_FLUSH = 2'd2
`endif
   } state_e;

`ifdef SHIFT_SCHED_FLUSH_EN
   localparam state_e RESET_STATE = ST_FLUSH;
`else
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   // Ceiling log2, evaluated at elaboration for counter/index widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping at NREQ-1.
module rr_arbiter
   import shift_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_idx,
   output logic            o_valid
);

   logic [PW:0] w_k;

   // Scan from the farthest offset down so the nearest requester is written last and wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_k     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_k = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_k >= (PW+1)'(NREQ)) w_k = w_k - (PW+1)'(NREQ);
         if (i_req[w_k[PW-1:0]]) begin
            o_grant                = '0;
            o_grant[w_k[PW-1:0]]   = 1'b1;
            o_idx                  = w_k[PW-1:0];
            o_valid                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one serial shift register between NREQ requesters.
// Define SHIFT_SCHED_FLUSH_EN to zero-fill the register for LEN cycles after reset.
module shift_sched
   import shift_sched_pkg::*;
#(
   parameter int LEN   = 8,
   parameter int NREQ  = 2,
   parameter int BURST = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [NREQ-1:0] i_req,
   input  logic [NREQ-1:0] i_data,
   output logic [NREQ-1:0] o_grant,
   output logic            o_ce,
   output logic            o_sr_data,
   output logic            o_busy,
   output logic            o_done
);

   localparam int CW = clog2(BURST) + 1;
   localparam int PW = clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || BURST < 1 || BURST > 256 || LEN < 1) begin : g_bad_params
      $error("shift_sched: parameter out of range");
   end

   state_e          r_state;
   state_e          w_next;
   logic [CW-1:0]   r_cnt;
   logic [NREQ-1:0] r_grant;
   logic [PW-1:0]   r_gidx;
   logic [PW-1:0]   r_ptr;
   logic            r_done;
   logic            w_ce;
   logic            w_sr_data;
   logic            w_last;
   logic [PW-1:0]   w_ptr_nxt;
   logic [NREQ-1:0] w_arb_grant;
   logic [PW-1:0]   w_arb_idx;
   logic            w_arb_valid;

`ifdef SHIFT_SCHED_FLUSH_EN
   localparam int FW = clog2(LEN) + 1;
   logic [FW-1:0]   r_fcnt;
`endif

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_ptr_nxt = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);

   always_comb begin
      w_next    = r_state;
      w_ce      = 1'b0;
      w_sr_data = 1'b0;
      w_last    = 1'b0;
      case (r_state)
`ifdef SHIFT_SCHED_FLUSH_EN
         ST_FLUSH: begin
            w_ce = 1'b1;
            if (r_fcnt == FW'(LEN - 1)) w_next = ST_IDLE;
         end
`endif
         ST_IDLE: begin
            if (w_arb_valid) w_next = ST_BURST;
         end
         ST_BURST: begin
            // The granted requester's request line is the shift enable; dropping it aborts.
            w_ce      = i_req[r_gidx];
            w_sr_data = w_ce & i_data[r_gidx];
            w_last    = w_ce && (r_cnt == CW'(BURST - 1));
            if (!w_ce || w_last) w_next = ST_IDLE;
         end
         default: w_next = RESET_STATE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= RESET_STATE;
         r_cnt   <= '0;
         r_grant <= '0;
         r_gidx  <= '0;
         r_ptr   <= '0;
         r_done  <= 1'b0;
`ifdef SHIFT_SCHED_FLUSH_EN
         r_fcnt  <= '0;
`endif
      end else begin
         r_state <= w_next;
         r_done  <= w_last;
`ifdef SHIFT_SCHED_FLUSH_EN
         if (r_state == ST_FLUSH && w_next == ST_FLUSH) r_fcnt <= r_fcnt + FW'(1);
`endif
         if (r_state == ST_IDLE && w_arb_valid) begin
            r_grant <= w_arb_grant;
            r_gidx  <= w_arb_idx;
            r_cnt   <= '0;
         end
         if (r_state == ST_BURST) begin
            if (w_ce) r_cnt <= r_cnt + CW'(1);
            // Completion and abort both hand priority to the next requester.
            if (w_next == ST_IDLE) begin
               r_grant <= '0;
               r_ptr   <= w_ptr_nxt;
            end
         end
      end
   end

   assign o_grant   = r_grant;
   assign o_ce      = w_ce;
   assign o_sr_data = w_sr_data;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_done    = r_done;

endmodule
